// File: rtl/mem_if_pkg.sv
// mem_if_pkg
// Definitions shared between the data-memory access sequencer and the
// two-lane byte memory responder.
//   LANE_W        : width of one byte lane
//   FUNCT3_*      : load/store width codes used by the sequencer
//   state_t       : responder FSM encoding (CLEAR sweep / READY)
package mem_if_pkg;

    localparam int LANE_W = 8;

    localparam logic [2:0] FUNCT3_B  = 3'b000;
    localparam logic [2:0] FUNCT3_H  = 3'b001;
    localparam logic [2:0] FUNCT3_W  = 3'b010;
    localparam logic [2:0] FUNCT3_BU = 3'b100;
    localparam logic [2:0] FUNCT3_HU = 3'b101;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

endpackage

// File: rtl/data_byte_ram_if.sv
// data_byte_ram_if
// Two-lane byte memory bus between the access sequencer (master) and the
// byte RAM (slave).
//   en, we               : access strobe and write qualifier for both lanes
//   addr_a/b, data_a/b   : per-lane byte address and write byte
//   recv_data_a/b        : per-lane registered read byte (one cycle later)
//   busy                 : clear sweep in progress, accesses ignored
//   fault                : sticky out-of-range address flag
interface data_byte_ram_if;
    import mem_if_pkg::*;

    logic              en;
    logic              we;
    logic [31:0]       addr_a;
    logic [LANE_W-1:0] data_a;
    logic [31:0]       addr_b;
    logic [LANE_W-1:0] data_b;
    logic [LANE_W-1:0] recv_data_a;
    logic [LANE_W-1:0] recv_data_b;
    logic              busy;
    logic              fault;

    modport master (
        output en, we, addr_a, data_a, addr_b, data_b,
        input  recv_data_a, recv_data_b, busy, fault
    );

    modport slave (
        input  en, we, addr_a, data_a, addr_b, data_b,
        output recv_data_a, recv_data_b, busy, fault
    );

endinterface

// File: rtl/data_byte_ram_decode.sv
// ram_lane_decode
// Maps one lane's byte address onto the array: subtracts the base address
// (32-bit wrap, so addresses below the base land far out of range), checks
// the offset against the depth and extracts the array index.
//   i_addr     : lane byte address
//   o_in_range : offset lies inside the array
//   o_idx      : array index (low ADDR_W bits of the offset)
module ram_lane_decode #(
    parameter int          DEPTH     = 4096,
    parameter int          ADDR_W    = 12,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic [31:0]       i_addr,
    output logic              o_in_range,
    output logic [ADDR_W-1:0] o_idx
);

    logic [31:0] w_off;

    // Base subtract, range check and index extract
    always_comb begin
        w_off      = i_addr - BASE_ADDR;
        o_in_range = (w_off < 32'(DEPTH));
        o_idx      = w_off[ADDR_W-1:0];
    end

endmodule

// File: rtl/data_byte_ram.sv
// data_byte_ram
// Responder end of the two-lane byte memory interface. Both lanes share one
// byte array with two write and two read ports; reads are registered with a
// one-cycle latency and are read-first with respect to a same-cycle write.
// When INIT_CLEAR is set, every reset starts a zero-fill sweep (two bytes per
// cycle) during which busy is high and accesses are ignored.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of data_byte_ram_if
module data_byte_ram
    import mem_if_pkg::*;
#(
    parameter int          DEPTH      = 4096,
    parameter int          ADDR_W     = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter bit          INIT_CLEAR = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    data_byte_ram_if.slave  bus
);

    localparam state_t          RST_STATE = INIT_CLEAR ? ST_CLEAR : ST_READY;
    localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 2);

    logic [LANE_W-1:0] r_mem [DEPTH];

    state_t            r_state;
    logic              r_busy;
    logic [ADDR_W-1:0] r_cnt;
    logic [LANE_W-1:0] r_recv_a;
    logic [LANE_W-1:0] r_recv_b;
    logic              r_fault;

    logic              w_in_a;
    logic              w_in_b;
    logic [ADDR_W-1:0] w_idx_a;
    logic [ADDR_W-1:0] w_idx_b;
    logic              w_access;

    ram_lane_decode #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) u_dec_a (
        .i_addr     (bus.addr_a),
        .o_in_range (w_in_a),
        .o_idx      (w_idx_a)
    );

    ram_lane_decode #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) u_dec_b (
        .i_addr     (bus.addr_b),
        .o_in_range (w_in_b),
        .o_idx      (w_idx_b)
    );

    // An access is only honoured once the clear sweep has finished
    always_comb begin
        w_access = (r_state == ST_READY) && bus.en;
    end

    // Array writes: zero-fill pair during the sweep, lane writes when ready.
    // Lane B is written after lane A so it wins on a same-index collision.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == ST_CLEAR) begin
                r_mem[r_cnt]                  <= {LANE_W{1'b0}};
                r_mem[r_cnt | ADDR_W'(1)]     <= {LANE_W{1'b0}};
            end else if (w_access && bus.we) begin
                if (w_in_a) begin
                    r_mem[w_idx_a] <= bus.data_a;
                end
                if (w_in_b) begin
                    r_mem[w_idx_b] <= bus.data_b;
                end
            end
        end
    end

    // FSM, sweep counter, read registers and sticky fault flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= RST_STATE;
            r_busy   <= INIT_CLEAR;
            r_cnt    <= {ADDR_W{1'b0}};
            r_recv_a <= {LANE_W{1'b0}};
            r_recv_b <= {LANE_W{1'b0}};
            r_fault  <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_cnt    <= r_cnt + ADDR_W'(2);
                    r_recv_a <= {LANE_W{1'b0}};
                    r_recv_b <= {LANE_W{1'b0}};
                    if (r_cnt == CNT_LAST) begin
                        r_state <= ST_READY;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= ST_CLEAR;
                        r_busy  <= 1'b1;
                    end
                end
                ST_READY: begin
                    r_busy <= 1'b0;
                    if (bus.en) begin
                        // Read-first: the old byte is captured even on a write
                        r_recv_a <= w_in_a ? r_mem[w_idx_a] : {LANE_W{1'b0}};
                        r_recv_b <= w_in_b ? r_mem[w_idx_b] : {LANE_W{1'b0}};
                        if (!w_in_a || !w_in_b) begin
                            r_fault <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_READY;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.recv_data_a = r_recv_a;
    assign bus.recv_data_b = r_recv_b;
    assign bus.busy        = r_busy;
    assign bus.fault       = r_fault;

endmodule
